// File: rtl/neuron_mac.sv
// Single-neuron MAC: accumulates N_INPUTS pixel*weight products, adds bias, applies saturating ReLU.
// out_valid pulses three edges after the last accepted sample; no backpressure, start honoured only in IDLE.
module neuron_mac #(
    parameter int N_INPUTS  = 784,
    parameter int PIXEL_W   = 8,
    parameter int WEIGHT_W  = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [PIXEL_W-1:0]         pixel,
    input  logic signed [WEIGHT_W-1:0] weight,
    input  logic signed [WEIGHT_W-1:0] bias,
    output logic [9:0]                 in_index,
    output logic                       busy,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data
);

    localparam int IDX_W  = 10;
    localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;

    logic signed [PROD_W-1:0] wt_ext, pix_ext, prod;
    logic signed [ACC_W-1:0]  prod_acc, bias_acc, shifted;
    logic [OUT_W-1:0]         relu_sat;

    // Pixel is zero-extended and weight sign-extended so the product is a plain signed multiply.
    assign wt_ext   = {{(PROD_W-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
    assign pix_ext  = {{(PROD_W-PIXEL_W){1'b0}}, pixel};
    assign prod     = wt_ext * pix_ext;
    assign prod_acc = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_acc = {{(ACC_W-WEIGHT_W){bias[WEIGHT_W-1]}}, bias};

    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        relu_sat = shifted[OUT_W-1:0];
        if (shifted[ACC_W-1]) begin
            relu_sat = '0;
        end else if (|shifted[ACC_W-1:OUT_W]) begin
            relu_sat = '1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_acc;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_BIAS: begin
                // Bias already carries FRAC_BITS fractional bits, so it adds unshifted.
                acc_d   = acc_q + bias_acc;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = relu_sat;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_index  = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
